// File: rtl/beta_wb_stage.sv
// Writeback stage: waits for the execution result of the current instruction, issues a
// single-cycle register-file write and forwards the written value into decode operands.
module beta_wb_stage #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Embedded  = 0
) (
   input  logic                 clk_i,
   input  logic                 rst_i,

   input  logic                 wb_new_instr_i,
   input  logic [4:0]           wb_rd_addr_i,
   input  logic                 wb_reg_write_i,
   input  logic [4:0]           wb_rsrc1_addr_i,
   input  logic [4:0]           wb_rsrc2_addr_i,
   input  logic [DataWidth-1:0] wb_result_i,
   input  logic                 wb_result_valid_i,

   output logic [DataWidth-1:0] wb_rd_wdata_o,
   output logic [4:0]           wb_rd_addr_o,
   output logic                 wb_reg_wr_en_o,
   output logic                 wb_forward_en_o,
   output logic [1:0]           wb_forward_src_o,
   output logic                 wb_stage_busy_o,
   output logic                 wb_overlap_err_o,
   output logic [31:0]          wb_retired_cnt_o
);

   typedef enum logic [1:0] {
      StIdle,
      StWaitRes,
      StWrite
   } wb_state_e;

   wb_state_e            state_q;
   logic [4:0]           cap_rd_q;
   logic                 cap_we_q;
   logic [DataWidth-1:0] rd_wdata_q;
   logic [4:0]           rd_addr_q;
   logic                 wr_en_q;
   logic                 overlap_q;
   logic [31:0]          retired_cnt_q;
   logic [31:0]          retired_cnt_d;
   logic                 rd_writable;
   logic [1:0]           fwd_src;

   // RV32E has only x0-x15, so any rd with bit 4 set is silently dropped.
   assign rd_writable = cap_we_q && (cap_rd_q != 5'd0) &&
                        ((Embedded == 0) || !cap_rd_q[4]);

   assign retired_cnt_d = retired_cnt_q + 32'd1;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= StIdle;
         cap_rd_q      <= 5'd0;
         cap_we_q      <= 1'b0;
         rd_wdata_q    <= '0;
         rd_addr_q     <= 5'd0;
         wr_en_q       <= 1'b0;
         overlap_q     <= 1'b0;
         retired_cnt_q <= 32'd0;
      end else begin
         wr_en_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (wb_new_instr_i) begin
                  cap_rd_q <= wb_rd_addr_i;
                  cap_we_q <= wb_reg_write_i;
                  state_q  <= StWaitRes;
               end
            end
            StWaitRes: begin
               // A second instruction before the result arrives is a protocol violation.
               if (wb_new_instr_i) begin
                  overlap_q <= 1'b1;
               end
               if (wb_result_valid_i) begin
                  rd_wdata_q    <= wb_result_i;
                  rd_addr_q     <= cap_rd_q;
                  retired_cnt_q <= retired_cnt_d;
                  if (rd_writable) begin
                     wr_en_q <= 1'b1;
                     state_q <= StWrite;
                  end else begin
                     state_q <= StIdle;
                  end
               end
            end
            StWrite: begin
               if (wb_new_instr_i) begin
                  cap_rd_q <= wb_rd_addr_i;
                  cap_we_q <= wb_reg_write_i;
                  state_q  <= StWaitRes;
               end else begin
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   // Only the write cycle needs a bypass; afterwards the regfile holds the value.
   always_comb begin
      fwd_src = 2'b00;
      if (state_q == StWrite) begin
         fwd_src[0] = (wb_rsrc1_addr_i == rd_addr_q);
         fwd_src[1] = (wb_rsrc2_addr_i == rd_addr_q);
      end
   end

   assign wb_rd_wdata_o    = rd_wdata_q;
   assign wb_rd_addr_o     = rd_addr_q;
   assign wb_reg_wr_en_o   = wr_en_q;
   assign wb_forward_src_o = fwd_src;
   assign wb_forward_en_o  = |fwd_src;
   assign wb_stage_busy_o  = (state_q != StIdle);
   assign wb_overlap_err_o = overlap_q;
   assign wb_retired_cnt_o = retired_cnt_q;

endmodule

// File: tb/tb_beta_wb_stage.sv
// Directed-vector bench for beta_wb_stage: one RV32I and one RV32E instance share stimulus.
module tb_beta_wb_stage;

   logic        clk_i;
   logic        rst_i;
   logic        new_instr;
   logic [4:0]  rd_addr;
   logic        reg_write;
   logic [4:0]  rsrc1;
   logic [4:0]  rsrc2;
   logic [31:0] result;
   logic        result_valid;

   logic [31:0] wdata,    wdata_e;
   logic [4:0]  waddr,    waddr_e;
   logic        wr_en,    wr_en_e;
   logic        fwd_en,   fwd_en_e;
   logic [1:0]  fwd_src,  fwd_src_e;
   logic        busy,     busy_e;
   logic        ovl_err,  ovl_err_e;
   logic [31:0] cnt,      cnt_e;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;

   beta_wb_stage #(.DataWidth(32), .Embedded(0)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .wb_new_instr_i   (new_instr),
      .wb_rd_addr_i     (rd_addr),
      .wb_reg_write_i   (reg_write),
      .wb_rsrc1_addr_i  (rsrc1),
      .wb_rsrc2_addr_i  (rsrc2),
      .wb_result_i      (result),
      .wb_result_valid_i(result_valid),
      .wb_rd_wdata_o    (wdata),
      .wb_rd_addr_o     (waddr),
      .wb_reg_wr_en_o   (wr_en),
      .wb_forward_en_o  (fwd_en),
      .wb_forward_src_o (fwd_src),
      .wb_stage_busy_o  (busy),
      .wb_overlap_err_o (ovl_err),
      .wb_retired_cnt_o (cnt)
   );

   beta_wb_stage #(.DataWidth(32), .Embedded(1)) dut_e (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .wb_new_instr_i   (new_instr),
      .wb_rd_addr_i     (rd_addr),
      .wb_reg_write_i   (reg_write),
      .wb_rsrc1_addr_i  (rsrc1),
      .wb_rsrc2_addr_i  (rsrc2),
      .wb_result_i      (result),
      .wb_result_valid_i(result_valid),
      .wb_rd_wdata_o    (wdata_e),
      .wb_rd_addr_o     (waddr_e),
      .wb_reg_wr_en_o   (wr_en_e),
      .wb_forward_en_o  (fwd_en_e),
      .wb_forward_src_o (fwd_src_e),
      .wb_stage_busy_o  (busy_e),
      .wb_overlap_err_o (ovl_err_e),
      .wb_retired_cnt_o (cnt_e)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, want $finish before 100000");
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_wdata"}, wdata, 32'h0);
      check_val({tag, "_waddr"}, {27'h0, waddr}, 32'h0);
      check_val({tag, "_wr_en"}, {31'h0, wr_en}, 32'h0);
      check_val({tag, "_fwd_en"}, {31'h0, fwd_en}, 32'h0);
      check_val({tag, "_fwd_src"}, {30'h0, fwd_src}, 32'h0);
      check_val({tag, "_busy"}, {31'h0, busy}, 32'h0);
      check_val({tag, "_ovl"}, {31'h0, ovl_err}, 32'h0);
      check_val({tag, "_cnt"}, cnt, 32'h0);
   endtask

   initial begin
      rst_i        = 1'b1;
      new_instr    = 1'b0;
      rd_addr      = 5'd0;
      reg_write    = 1'b0;
      rsrc1        = 5'd0;
      rsrc2        = 5'd0;
      result       = 32'h0;
      result_valid = 1'b0;
      #12;
      check_all_zero("reset");
      rst_i = 1'b0;

      // Basic write of rd=5 with result two cycles after the instruction
      new_instr = 1'b1; rd_addr = 5'd5; reg_write = 1'b1;
      tick();
      new_instr = 1'b0;
      check_val("wait_busy", {31'h0, busy}, 32'h1);
      check_val("wait_no_wr", {31'h0, wr_en}, 32'h0);
      tick();
      result_valid = 1'b1; result = 32'hDEAD_BEEF;
      #1;
      check_val("res_cycle_no_wr", {31'h0, wr_en}, 32'h0);
      tick();
      result_valid = 1'b0; rsrc1 = 5'd5; rsrc2 = 5'd5;
      #1;
      check_val("w1_wr_en", {31'h0, wr_en}, 32'h1);
      check_val("w1_addr", {27'h0, waddr}, 32'd5);
      check_val("w1_wdata", wdata, 32'hDEAD_BEEF);
      check_val("w1_cnt", cnt, 32'd1);
      check_val("w1_fwd_en", {31'h0, fwd_en}, 32'h1);
      check_val("w1_fwd_src", {30'h0, fwd_src}, 32'h3);
      check_val("w1e_wr_en", {31'h0, wr_en_e}, 32'h1);
      tick();
      check_val("w1_post_wr_en", {31'h0, wr_en}, 32'h0);
      check_val("w1_post_fwd_en", {31'h0, fwd_en}, 32'h0);
      check_val("w1_post_fwd_src", {30'h0, fwd_src}, 32'h0);
      check_val("w1_post_busy", {31'h0, busy}, 32'h0);
      check_val("w1_hold_wdata", wdata, 32'hDEAD_BEEF);

      // rd=0 with reg_write: retires without a write
      new_instr = 1'b1; rd_addr = 5'd0; reg_write = 1'b1;
      tick();
      new_instr = 1'b0; result_valid = 1'b1; result = 32'h0000_1234;
      tick();
      result_valid = 1'b0;
      check_val("rd0_wr_en", {31'h0, wr_en}, 32'h0);
      check_val("rd0_busy", {31'h0, busy}, 32'h0);
      check_val("rd0_cnt", cnt, 32'd2);
      check_val("rd0_wdata", wdata, 32'h0000_1234);

      // reg_write=0 with a non-zero rd: no write either
      new_instr = 1'b1; rd_addr = 5'd7; reg_write = 1'b0;
      tick();
      new_instr = 1'b0; result_valid = 1'b1; result = 32'h0000_0777;
      tick();
      result_valid = 1'b0;
      check_val("nowe_wr_en", {31'h0, wr_en}, 32'h0);
      check_val("nowe_cnt", cnt, 32'd3);
      check_val("nowe_addr", {27'h0, waddr}, 32'd7);

      // A result in IDLE is ignored
      result_valid = 1'b1; result = 32'hFFFF_0000;
      tick();
      result_valid = 1'b0;
      check_val("idle_res_busy", {31'h0, busy}, 32'h0);
      check_val("idle_res_wdata", wdata, 32'h0000_0777);
      check_val("idle_res_cnt", cnt, 32'd3);

      // rd=17: legal for RV32I, dropped for RV32E; back-to-back new instr in WRITE
      new_instr = 1'b1; rd_addr = 5'd17; reg_write = 1'b1;
      tick();
      new_instr = 1'b0; result_valid = 1'b1; result = 32'h1700_0017;
      tick();
      result_valid = 1'b0; rsrc1 = 5'd17; rsrc2 = 5'd2;
      new_instr = 1'b1; rd_addr = 5'd9; reg_write = 1'b1;
      #1;
      check_val("rd17_wr_en", {31'h0, wr_en}, 32'h1);
      check_val("rd17_addr", {27'h0, waddr}, 32'd17);
      check_val("rd17_fwd_src", {30'h0, fwd_src}, 32'h1);
      check_val("rd17e_wr_en", {31'h0, wr_en_e}, 32'h0);
      check_val("rd17e_busy", {31'h0, busy_e}, 32'h0);
      check_val("rd17e_fwd_src", {30'h0, fwd_src_e}, 32'h0);
      check_val("rd17e_cnt", cnt_e, 32'd4);
      tick();
      new_instr = 1'b0;
      check_val("b2b_busy", {31'h0, busy}, 32'h1);
      check_val("b2b_wr_en", {31'h0, wr_en}, 32'h0);
      result_valid = 1'b1; result = 32'h0000_A5A5;
      tick();
      result_valid = 1'b0;
      check_val("b2b_wr_en2", {31'h0, wr_en}, 32'h1);
      check_val("b2b_addr", {27'h0, waddr}, 32'd9);
      check_val("b2b_cnt", cnt, 32'd5);
      check_val("b2be_wr_en", {31'h0, wr_en_e}, 32'h1);
      tick();

      // Overlap: second instruction while waiting, then result with a coincident pulse
      new_instr = 1'b1; rd_addr = 5'd3; reg_write = 1'b1;
      tick();
      rd_addr = 5'd12;
      tick();
      check_val("ovl_set", {31'h0, ovl_err}, 32'h1);
      check_val("ovl_busy", {31'h0, busy}, 32'h1);
      result_valid = 1'b1; result = 32'h0000_0055;
      tick();
      new_instr = 1'b0; result_valid = 1'b0;
      check_val("ovl_wr_en", {31'h0, wr_en}, 32'h1);
      check_val("ovl_addr", {27'h0, waddr}, 32'd3);
      check_val("ovl_cnt", cnt, 32'd6);
      tick();
      check_val("ovl_sticky", {31'h0, ovl_err}, 32'h1);
      check_val("ovl_idle", {31'h0, busy}, 32'h0);

      // Asynchronous reset while waiting for a result
      new_instr = 1'b1; rd_addr = 5'd4; reg_write = 1'b1;
      tick();
      new_instr = 1'b0;
      #2;
      rst_i = 1'b1;
      #1;
      check_all_zero("arst");
      #2;
      rst_i = 1'b0;
      result_valid = 1'b1; result = 32'h0000_0444;
      tick();
      result_valid = 1'b0;
      check_val("post_rst_busy", {31'h0, busy}, 32'h0);
      check_val("post_rst_wr_en", {31'h0, wr_en}, 32'h0);
      check_val("post_rst_cnt", cnt, 32'd0);

      // Counter wrap on the RV32I instance
      force dut.retired_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.retired_cnt_q;
      new_instr = 1'b1; rd_addr = 5'd6; reg_write = 1'b1;
      tick();
      new_instr = 1'b0; result_valid = 1'b1; result = 32'h0000_600D;
      tick();
      result_valid = 1'b0;
      check_val("wrap_cnt", cnt, 32'h0);
      check_val("wrap_wr_en", {31'h0, wr_en}, 32'h1);
      check_val("wrap_cnt_e", cnt_e, 32'd1);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/beta_wb_stage.md
BETA_WB_STAGE -- requirements
Module: beta_wb_stage

Interface
REQ-001 SHALL have parameter DataWidth, default 32; width of data lines (only 32 supported).
REQ-002 SHALL have parameter Embedded, default 0; 1 = RV32E profile, so rd addresses 16-31 are invalid.
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk_i input 1 (rising edge), then rst_i input 1.
REQ-004 wb_new_instr_i  in  1  new decoded instruction presented, single-cycle pulse.
REQ-005 wb_rd_addr_i  in  5  destination register of the presented instruction.
REQ-006 wb_reg_write_i  in  1  instruction writes rd (control-word bit).
REQ-007 wb_rsrc1_addr_i / wb_rsrc2_addr_i  in  5 each  source addresses of the instruction currently in decode.
REQ-008 wb_result_i  in  DataWidth  execution result.
REQ-009 wb_result_valid_i  in  1  wb_result_i is valid this cycle.
REQ-010 wb_rd_wdata_o  out  DataWidth  registered regfile write data; also the forwarding data.
REQ-011 wb_rd_addr_o  out  5  registered regfile write address.
REQ-012 wb_reg_wr_en_o  out  1  regfile write enable.
REQ-013 wb_forward_en_o  out  1  forward wb_rd_wdata_o into decode operands.
REQ-014 wb_forward_src_o  out  2  bit0 = operand A, bit1 = operand B.
REQ-015 wb_stage_busy_o  out  1  stage not IDLE.
REQ-016 wb_overlap_err_o  out  1  sticky protocol-violation flag.
REQ-017 wb_retired_cnt_o  out  32  count of completed instructions.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT_RES, WRITE.
REQ-019 IDLE + wb_new_instr_i: SHALL capture rd_addr and reg_write, then go to WAIT_RES; wb_result_valid_i SHALL be ignored in IDLE.
REQ-020 WAIT_RES + wb_result_valid_i: SHALL register wb_result_i into wb_rd_wdata_o and the captured rd into wb_rd_addr_o.
  - Next state WRITE if reg_write=1, rd!=0 and rd is valid (Embedded=1: rd[4]=0).
  - Otherwise next state IDLE, with no write.
REQ-021 WRITE: wb_reg_wr_en_o SHALL be 1 for exactly one cycle, then go to IDLE.
  - If wb_new_instr_i is high in WRITE, SHALL capture the new instruction and go directly to WAIT_RES.
REQ-022 Latency: result valid in cycle N SHALL give wb_reg_wr_en_o high in cycle N+1; at most one write per instruction.
REQ-023 wb_new_instr_i in WAIT_RES SHALL be ignored; wb_overlap_err_o SHALL be set and held until reset.
REQ-024 wb_new_instr_i and wb_result_valid_i together in WAIT_RES: the result SHALL complete the current instruction; the new pulse SHALL be treated as an overlap per REQ-023.
REQ-025 Forwarding (combinational):
  - wb_forward_src_o[0] = (state==WRITE) & (wb_rsrc1_addr_i==wb_rd_addr_o).
  - wb_forward_src_o[1] = (state==WRITE) & (wb_rsrc2_addr_i==wb_rd_addr_o).
  - wb_forward_en_o = OR of both bits.
  - No forwarding in any other state (the regfile already holds the value after the write edge).
REQ-026 wb_rd_wdata_o and wb_rd_addr_o SHALL hold their values until the next result capture.
REQ-027 wb_retired_cnt_o SHALL increment by 1 on each WAIT_RES exit (write or no write) and SHALL wrap 0xFFFFFFFF -> 0.
REQ-028 wb_stage_busy_o SHALL be (state != IDLE).

Reset
REQ-029 rst_i high SHALL asynchronously force: state IDLE; wb_rd_wdata_o, wb_rd_addr_o, wb_reg_wr_en_o, wb_forward_en_o, wb_forward_src_o, wb_stage_busy_o, wb_overlap_err_o, wb_retired_cnt_o all 0.
REQ-030 Reset asserted mid-operation (WAIT_RES or WRITE) SHALL abort the instruction with no write; after release, the block SHALL accept a new instruction only on a fresh wb_new_instr_i.

Verification
REQ-031 new_instr (rd=5, reg_write=1); 2 cycles later result_valid, result=0xDEADBEEF -> next cycle wr_en=1, addr=5, wdata=0xDEADBEEF for one cycle; cnt=1.
REQ-032 In the WRITE cycle of REQ-031 drive rsrc1=5, rsrc2=5 -> forward_en=1, forward_src=2'b11; next cycle forward_en=0.
REQ-033 rd=0 with reg_write=1, then result_valid -> no wr_en pulse, state returns to IDLE, cnt increments.
REQ-034 Embedded=1, rd=17 -> no write; Embedded=0, rd=17 -> write occurs.
REQ-035 Second new_instr while in WAIT_RES -> overlap_err=1 (sticky); first instruction still completes with its own rd.
REQ-036 Reset mid-operation and counter wrap:
  - Assert rst_i asynchronously in WAIT_RES -> all outputs 0 immediately.
  - Preload cnt=0xFFFFFFFF and retire one instruction -> cnt=0.
